// File: rtl/lcd_scan_if.sv
// lcd_scan_if: bundles the lcd_scan control, frame-store write port and raster outputs.
//   master: pix_ce, lcdon, i_vram_a/do/we out; o_pix/o_de/o_hs/o_vs/o_frame in
//   slave : the reverse direction, used by lcd_scan itself
interface lcd_scan_if;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned NIB_W  = 4;

  logic              pix_ce;
  logic              lcdon;
  logic [ADDR_W-1:0] i_vram_a;
  logic [NIB_W-1:0]  i_vram_do;
  logic              i_vram_we;
  logic              o_pix;
  logic              o_de;
  logic              o_hs;
  logic              o_vs;
  logic              o_frame;

  modport master (
    output pix_ce, lcdon, i_vram_a, i_vram_do, i_vram_we,
    input  o_pix, o_de, o_hs, o_vs, o_frame
  );

  modport slave (
    input  pix_ce, lcdon, i_vram_a, i_vram_do, i_vram_we,
    output o_pix, o_de, o_hs, o_vs, o_frame
  );
endinterface

// File: rtl/lcd_scan.sv
// lcd_scan: 64x256-nibble frame store scanned out as a 640x480@60 raster.
// Each stored line is shown 6 times in a 384-line window starting at vcnt 48.
// Ports:
//   mck     master clock, all logic on the rising edge
//   rin     synchronous reset, active-high
//   bus     lcd_scan_if.slave: pix_ce, lcdon, i_vram_a/do/we in;
//           o_pix, o_de, o_hs (low), o_vs (low), o_frame out (all registered)
// Build option: define LCD_SCAN_BORDER_EN to light vcnt 47 and 432 across the active width.
module lcd_scan (
  input  logic      mck,
  input  logic      rin,
  lcd_scan_if.slave bus
);
  localparam int unsigned CNT_W = 10;
  localparam int unsigned REP_W = 3;
  localparam int unsigned ZL_W  = 6;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned OFF_W = 2;
  localparam int unsigned DEPTH = 16384;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(799);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(640);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(656);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(752);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(524);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(480);
  localparam logic [CNT_W-1:0] V_FRM    = CNT_W'(479);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(490);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(492);
  localparam logic [CNT_W-1:0] WIN_PRE  = CNT_W'(47);
  localparam logic [CNT_W-1:0] WIN_BEG  = CNT_W'(48);
  localparam logic [CNT_W-1:0] WIN_END  = CNT_W'(432);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(5);

  logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [ZL_W-1:0]  zline_q, zline_d;
  // stage 1: raster attributes of the current counter position
  logic             de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic             win1_q, win1_d, bdr1_q, bdr1_d;
  logic [OFF_W-1:0] off1_q, off1_d;
  // stage 2: output registers
  logic             pix_q, pix_d, de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic             frame_q, frame_d;

  logic [NIB_W-1:0] mem [DEPTH];
  logic [NIB_W-1:0] nib_q;

  logic line_end_c, in_win_c, fetch_c, border_c;

  assign line_end_c = (hcnt_q == H_LAST);
  assign in_win_c   = (vcnt_q >= WIN_BEG) && (vcnt_q < WIN_END);
  // nibbles beyond 159 sit past the active width and are never fetched
  assign fetch_c    = bus.pix_ce && (hcnt_q[1:0] == 2'd0) && (hcnt_q < H_ACT);

`ifdef LCD_SCAN_BORDER_EN
  assign border_c = ((vcnt_q == WIN_PRE) || (vcnt_q == WIN_END)) && (hcnt_q < H_ACT);
`else
  assign border_c = 1'b0;
`endif

  // Frame store: write any cycle; fetch reads old data on a same-address write
  always_ff @(posedge mck) begin
    if (fetch_c) begin
      nib_q <= mem[{zline_q, hcnt_q[9:2]}];
    end
    if (bus.i_vram_we) begin
      mem[bus.i_vram_a] <= bus.i_vram_do;
    end
  end

  // Raster counters, line mapping and two-stage output pipeline
  always_comb begin
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    rep_d   = rep_q;
    zline_d = zline_q;
    de1_d   = de1_q;
    hs1_d   = hs1_q;
    vs1_d   = vs1_q;
    win1_d  = win1_q;
    bdr1_d  = bdr1_q;
    off1_d  = off1_q;
    pix_d   = pix_q;
    de_d    = de_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    frame_d = 1'b0;
    if (bus.pix_ce) begin
      hcnt_d = line_end_c ? '0 : hcnt_q + CNT_W'(1);
      if (line_end_c) begin
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CNT_W'(1);
        // rep/zline walk the window six display lines per stored line
        if (vcnt_q == WIN_PRE) begin
          rep_d   = '0;
          zline_d = '0;
        end else if (in_win_c) begin
          if (rep_q == REP_LAST) begin
            rep_d   = '0;
            zline_d = zline_q + ZL_W'(1);
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
        end
      end
      de1_d   = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
      hs1_d   = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
      vs1_d   = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
      win1_d  = in_win_c && (hcnt_q < H_ACT);
      bdr1_d  = border_c;
      off1_d  = hcnt_q[1:0];
      // offset 0 selects bit 3 (leftmost pixel)
      pix_d   = bus.lcdon && ((win1_q && nib_q[~off1_q]) || bdr1_q);
      de_d    = de1_q;
      hs_d    = hs1_q;
      vs_d    = vs1_q;
      frame_d = line_end_c && (vcnt_q == V_FRM);
    end
  end

  always_ff @(posedge mck) begin
    if (rin) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      rep_q   <= '0;
      zline_q <= '0;
      de1_q   <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      win1_q  <= 1'b0;
      bdr1_q  <= 1'b0;
      off1_q  <= '0;
      pix_q   <= 1'b0;
      de_q    <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      rep_q   <= rep_d;
      zline_q <= zline_d;
      de1_q   <= de1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      win1_q  <= win1_d;
      bdr1_q  <= bdr1_d;
      off1_q  <= off1_d;
      pix_q   <= pix_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      frame_q <= frame_d;
    end
  end

  assign bus.o_pix   = pix_q;
  assign bus.o_de    = de_q;
  assign bus.o_hs    = hs_q;
  assign bus.o_vs    = vs_q;
  assign bus.o_frame = frame_q;
endmodule

// File: tb/tb_lcd_scan.sv
// tb_lcd_scan: table-driven startup vectors plus a long randomized scan
// compared against a raster model built from position arithmetic.
module tb_lcd_scan;
  logic mck = 1'b0;
  logic rin;

  lcd_scan_if bus ();

  lcd_scan dut (
    .mck (mck),
    .rin (rin),
    .bus (bus)
  );

  always #5 mck = ~mck;

  typedef struct packed {
    logic pix;
    logic de;
    logic hs;
    logic vs;
  } vout_t;

  typedef struct {
    logic [13:0] a;
    logic [3:0]  d;
  } wr_t;

  typedef struct {
    logic rin;
    logic pce;
    logic [4:0] exp;   // {pix, de, hs, vs, frame}
  } vec_t;

  localparam vout_t IDLE = '{pix: 1'b0, de: 1'b0, hs: 1'b1, vs: 1'b1};

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [3:0] ref_mem [16384];
  logic [3:0] ref_nib = 4'd0;
  int    mh = 0, mv = 0;
  vout_t st1 = IDLE, expo = IDLE;
  int    s1_v = -1, s1_h = -1, o_v = -1, o_h = -1;
  logic  exp_frame = 1'b0;
  bit    adv = 0;

  // line statistics
  int    ncyc = 0, last_fall = -1, hs_period_exp = 800;
  int    hs_low = 0, de_cnt = 0;
  logic  prev_hs = 1'b1;

  wr_t   wq[$];

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic fail_done();
    errors++;
    if (errors >= 40) finish_run();
  endtask

  function automatic vout_t raster(int h, int v, logic [3:0] nib, logic on);
    vout_t r;
    bit win, bdr;
    win = (v >= 48) && (v < 432) && (h < 640);
    bdr = 0;
`ifdef LCD_SCAN_BORDER_EN
    bdr = ((v == 47) || (v == 432)) && (h < 640);
`endif
    r.de  = (h < 640) && (v < 480);
    r.hs  = !((h >= 656) && (h < 752));
    r.vs  = !((v >= 490) && (v <= 491));
    r.pix = on && ((win && nib[2'(3 - h % 4)]) || bdr);
    return r;
  endfunction

  task automatic model_edge(logic r, logic pce, logic on, logic we, logic [13:0] a, logic [3:0] d);
    exp_frame = 1'b0;
    adv = 0;
    if (r) begin
      mh = 0; mv = 0;
      st1 = IDLE; expo = IDLE;
      s1_v = -1; s1_h = -1; o_v = -1; o_h = -1;
    end else if (pce) begin
      adv = 1;
      exp_frame = (mh == 799) && (mv == 479);
      expo = st1; o_v = s1_v; o_h = s1_h;
      if ((mh % 4 == 0) && (mh < 640) && (mv >= 48) && (mv < 432))
        ref_nib = ref_mem[14'(((mv - 48) / 6) * 256 + mh / 4)];
      st1 = raster(mh, mv, ref_nib, on);
      s1_v = mv; s1_h = mh;
      mh++;
      if (mh == 800) begin
        mh = 0;
        mv = (mv + 1) % 525;
      end
    end
    // write after the fetch: same-cycle read sees old data
    if (we) ref_mem[a] = d;
  endtask

  task automatic directed();
    bit valid, want;
    valid = 0; want = 0;
    if (o_v >= 48 && o_v <= 53 && o_h >= 0 && o_h < 4) begin
      valid = 1; want = (o_h % 2 == 0);
    end else if (o_v == 54 && o_h >= 0 && o_h < 4) begin
      valid = 1; want = 0;
    end else if (o_v == 60 && o_h >= 0 && o_h < 640) begin
      valid = 1; want = 0;
      checks++;
      if (bus.o_de !== 1'b1) begin
        $display("FAIL lcdon_off_de v=%0d h=%0d got %b exp 1", o_v, o_h, bus.o_de);
        fail_done();
      end
`ifdef LCD_SCAN_BORDER_EN
    end else if (o_v == 47 && o_h >= 0 && o_h < 640) begin
      valid = 1; want = 1;
`endif
    end
    if (valid) begin
      checks++;
      if (bus.o_pix !== want) begin
        $display("FAIL directed_pix v=%0d h=%0d got %b exp %b", o_v, o_h, bus.o_pix, want);
        fail_done();
      end
    end
  endtask

  task automatic check_outputs();
    logic [4:0] got, exp;
    got = {bus.o_pix, bus.o_de, bus.o_hs, bus.o_vs, bus.o_frame};
    exp = {expo.pix, expo.de, expo.hs, expo.vs, exp_frame};
    checks++;
    if (got !== exp) begin
      $display("FAIL raster v=%0d h=%0d got %b exp %b", o_v, o_h, got, exp);
      fail_done();
    end
    if (adv && o_v >= 0) begin
      directed();
      hs_low += (bus.o_hs == 1'b0) ? 1 : 0;
      de_cnt += (bus.o_de == 1'b1) ? 1 : 0;
      if (prev_hs && !bus.o_hs) begin
        checks++;
        if (o_h != 656) begin
          $display("FAIL hs_start got h=%0d exp 656", o_h);
          fail_done();
        end
        if (last_fall >= 0) begin
          checks++;
          if (ncyc - last_fall != hs_period_exp) begin
            $display("FAIL hs_period got %0d exp %0d", ncyc - last_fall, hs_period_exp);
            fail_done();
          end
        end
        last_fall = ncyc;
      end
      if (o_h == 799) begin
        checks += 2;
        if (hs_low != 96) begin
          $display("FAIL hs_width v=%0d got %0d exp 96", o_v, hs_low);
          fail_done();
        end
        if (de_cnt != ((o_v < 480) ? 640 : 0)) begin
          $display("FAIL de_line v=%0d got %0d exp %0d", o_v, de_cnt, (o_v < 480) ? 640 : 0);
          fail_done();
        end
        hs_low = 0; de_cnt = 0;
      end
    end
    prev_hs = bus.o_hs;
  endtask

  task automatic cycle(logic r, logic pce, logic on, logic we, logic [13:0] a, logic [3:0] d);
    rin = r;
    bus.pix_ce = pce;
    bus.lcdon = on;
    bus.i_vram_we = we;
    bus.i_vram_a = a;
    bus.i_vram_do = d;
    @(posedge mck);
    model_edge(r, pce, on, we, a, d);
    ncyc++;
    if (r) begin
      last_fall = -1; hs_low = 0; de_cnt = 0;
    end
    @(negedge mck);
    check_outputs();
  endtask

  initial begin
    vec_t  vecs[11];
    wr_t   w;
    logic  on, we, tog;
    logic [13:0] a;
    logic [3:0]  d;
    int    pce_cnt;

    // startup vectors: {rin, pix_ce, expected {pix,de,hs,vs,frame}}
    vecs[0]  = '{1'b1, 1'b1, 5'b00110};
    vecs[1]  = '{1'b1, 1'b0, 5'b00110};
    vecs[2]  = '{1'b0, 1'b0, 5'b00110};
    vecs[3]  = '{1'b0, 1'b1, 5'b00110};
    vecs[4]  = '{1'b0, 1'b0, 5'b00110};
    vecs[5]  = '{1'b0, 1'b1, 5'b01110};
    vecs[6]  = '{1'b0, 1'b0, 5'b01110};
    vecs[7]  = '{1'b0, 1'b1, 5'b01110};
    vecs[8]  = '{1'b1, 1'b1, 5'b00110};
    vecs[9]  = '{1'b0, 1'b1, 5'b00110};
    vecs[10] = '{1'b0, 1'b1, 5'b01110};
    for (int i = 0; i < 11; i++) begin
      cycle(vecs[i].rin, vecs[i].pce, 1'b1, 1'b0, 14'd0, 4'd0);
      checks++;
      if ({bus.o_pix, bus.o_de, bus.o_hs, bus.o_vs, bus.o_frame} !== vecs[i].exp) begin
        $display("FAIL vec%0d got %b exp %b", i,
                 {bus.o_pix, bus.o_de, bus.o_hs, bus.o_vs, bus.o_frame}, vecs[i].exp);
        fail_done();
      end
    end

    // store image: zline 0 random (nibble 0 = 1010), zline 1 random (nibble 0 = 0),
    // zline 2 all F; undisplayed nibbles 160..255 filled too
    for (int z = 0; z < 3; z++) begin
      for (int n = 0; n < 256; n++) begin
        w.a = {6'(z), 8'(n)};
        w.d = (z == 2) ? 4'hF : 4'($urandom);
        if (z == 0 && n == 0) w.d = 4'b1010;
        if (z == 1 && n == 0) w.d = 4'h0;
        wq.push_back(w);
      end
    end
    w.a = {6'd5, 8'd200};  w.d = 4'hF; wq.push_back(w);
    w.a = {6'd63, 8'd159}; w.d = 4'hF; wq.push_back(w);

    // full-rate scan through display line 62; lcdon low for lines 60..62
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 14'd0, 4'd0);
    hs_period_exp = 800;
    on = 1'b1;
    for (int n = 0; n < 60000 && mv != 63; n++) begin
      if (mh == 700) on = !(mv >= 59 && mv <= 62);
      we = 1'b0; a = 14'd0; d = 4'd0;
      if (wq.size() > 0) begin
        w = wq.pop_front();
        we = 1'b1; a = w.a; d = w.d;
      end else if (mv >= 54 && mv <= 59 && $urandom_range(3) == 0) begin
        we = 1'b1;
        a = {6'd1, 8'($urandom_range(159, 1))};
        d = 4'($urandom);
      end
      cycle(1'b0, 1'b1, on, we, a, d);
    end
    checks++;
    if (mv != 63) begin
      $display("FAIL scan_budget got line %0d exp 63", mv);
      fail_done();
    end

    // half-rate pixel clock with a mid-line reset
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 14'd0, 4'd0);
    hs_period_exp = 1600;
    tog = 1'b0;
    for (int n = 0; n < 2200; n++) begin
      cycle(1'b0, tog, 1'b1, 1'b0, 14'd0, 4'd0);
      tog = !tog;
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 14'd0, 4'd0);
    checks++;
    if (bus.o_hs !== 1'b1 || bus.o_de !== 1'b0) begin
      $display("FAIL post_reset got hs=%b de=%b exp hs=1 de=0", bus.o_hs, bus.o_de);
      fail_done();
    end
    pce_cnt = 0;
    tog = 1'b0;
    for (int k = 0; k < 20 && bus.o_de !== 1'b1; k++) begin
      cycle(1'b0, tog, 1'b1, 1'b0, 14'd0, 4'd0);
      pce_cnt += tog ? 1 : 0;
      tog = !tog;
    end
    checks++;
    if (bus.o_de !== 1'b1 || pce_cnt != 2) begin
      $display("FAIL de_restart got de=%b after %0d pix_ce exp de=1 after 2", bus.o_de, pce_cnt);
      fail_done();
    end
    for (int n = 0; n < 5000; n++) begin
      cycle(1'b0, tog, 1'b1, 1'b0, 14'd0, 4'd0);
      tog = !tog;
    end

    finish_run();
  end
endmodule

// File: doc/lcd_scan.md
# lcd_scan

Downstream of the screen renderer. Stores the 4-bit pixel nibbles it writes into a 64-line × 256-nibble frame store and scans that store out as a 640×480@60 VGA-style raster: one pixel bit plus sync and data-enable. Each Z88 line is repeated 6 times vertically and placed in a window centred on the display. Write and scan-out run independently on one clock; pixel rate is set by a clock-enable strobe.

## Interface
- No parameters; all timing constants are fixed (see Timing).
- mck  in  1  master clock; all logic on rising edge
- rin  in  1  synchronous reset, active-high
- pix_ce  in  1  pixel clock enable; raster counters and output pipeline advance only when 1 (25 MHz rate intended)
- lcdon  in  1  LCD enable; 0 blanks pixel output
- i_vram_a  in  14  write address: [13:8] line 0..63, [7:0] nibble index
- i_vram_do  in  4  write nibble; bit 3 = leftmost pixel
- i_vram_we  in  1  write strobe, sampled every mck independent of pix_ce
- o_pix  out  1  pixel, 1 = lit (dark LCD dot)
- o_de  out  1  data enable, 1 in 640×480 active area
- o_hs  out  1  horizontal sync, active-low
- o_vs  out  1  vertical sync, active-low
- o_frame  out  1  one-mck pulse on the pix_ce that enters vcnt 480

## Operation
- Frame store: 16384×4, write port and read port on mck. Write when i_vram_we=1, any cycle, no back-pressure. Same-cycle read and write to one address returns old data (read-before-write). Contents are not cleared by reset.
- hcnt 0..799, vcnt 0..524. Both advance on pix_ce. hcnt wraps 799→0 and then increments vcnt. vcnt wraps 524→0.
- Window: vcnt 48..431 (384 lines) and hcnt 0..639. Outside the window inside the active area, o_pix=0.
- Line mapping uses no division:
  - rep counter 0..5 and zline 0..63.
  - Both clear when hcnt==799 and the next vcnt is 48.
  - At each hcnt 799→0 inside the window, rep increments. rep 5→0 increments zline.
- Fetch: when hcnt[1:0]==0 on pix_ce, read address {zline, hcnt[9:2]} is registered. Only nibble indices 0..159 are ever read; 160..255 are stored but never displayed.
- Pixel select uses hcnt[1:0] delayed to match RAM latency: offset 0→bit 3, 1→bit 2, 2→bit 1, 3→bit 0.
- lcdon=0: o_pix forced 0; sync and de unaffected; writes still accepted.
- Reset mid-frame: counters return to 0 on the next mck. No partial-line recovery is required.

## Timing
- Horizontal: active 0..639; hs low for hcnt 656..751.
- Vertical: active 0..479; vs low for vcnt 490..491.
- Pipeline: o_pix, o_de, o_hs and o_vs all lag the counters by exactly 2 pix_ce events, with equal delay so they stay aligned.
- Outputs are registered; they change only on mck edges where pix_ce=1, except o_frame.
- Reset values: o_pix=0, o_de=0, o_hs=1, o_vs=1, o_frame=0; hcnt=vcnt=rep=zline=0.
- Write-to-visible latency: a write lands in the store on the mck it is sampled. It is visible on any later fetch of that address.

## Configuration
- LCD_SCAN_BORDER_EN defined:
  - o_pix=1 on the 1-pixel rectangle just outside the window: vcnt 47 and 432 for hcnt 0..639.
  - The window spans the full active width, so there are no side edges.
  - Subject to lcdon like all pixels.
- Not defined: pixels outside the window are always 0.

## Test plan
- Reset, pix_ce=1 constant, 800×525 cycles:
  - o_hs low exactly 96 pixels per line, starting at pixel 656 (counted after the 2-cycle lag).
  - o_vs low for lines 490..491.
  - o_de high 640×480 per frame.
  - o_frame pulses once per frame.
- Write nibble 4'b1010 at line 0, nibble 0: first 4 pixels of display lines 48..53 are 1,0,1,0; line 54 pixels 0..3 are 0.
- Write 4'hF at {6'd63, 8'd159}: pixels 636..639 lit on display lines 426..431 only.
- Write to nibble 200 of line 5: no change on any displayed pixel.
- lcdon=0 with the store full of 4'hF: o_pix=0 everywhere, o_de/o_hs/o_vs unchanged.
- pix_ce every other mck, plus rin pulsed mid-line:
  - Raster period doubles in mck.
  - After reset, o_hs=1, o_de=0 and counting restarts at hcnt 0.
  - With LCD_SCAN_BORDER_EN, display line 47 is all 1 across hcnt 0..639.
